// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 serial transmitter paced by an external baud strobe.
// Accepts one byte over valid/ready, then shifts it out LSB-first with
// one start bit and one stop bit. Every bit holds for one tick period.
//
// Ports:
//   clk   - system clock, all logic on posedge
//   rst   - synchronous active-high reset
//   tick  - baud strobe, one clk cycle high per bit period
//   data  - byte to send, sampled on accept only
//   valid - producer offers a byte
//   ready - high only while idle; accept = valid && ready
//   tx    - registered serial line, idle high
//   busy  - inverse of ready
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit (11-bit frame).

module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shift;
  logic [2:0] cnt;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; everything except accept advances only on tick
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (valid) state_nxt = S_SYNC;
      S_SYNC:   if (tick) state_nxt = S_START;
      S_START:  if (tick) state_nxt = S_DATA;
      S_DATA: begin
        if (tick && cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) state_nxt = S_STOP;
`endif
      S_STOP:   if (tick) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    ready = (state == S_IDLE);
    busy  = (state != S_IDLE);
  end

  // Datapath: shift register, bit counter and registered line.
  // In DATA, tx takes shift[1] because shift[0] is already on the line
  // and the register shifts in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (valid) begin
            shift <= data;
`ifdef UART_TX_PARITY_EN
            par   <= ^data;
`endif
          end
        end
        S_SYNC: if (tick) tx <= 1'b0;
        S_START: begin
          if (tick) begin
            tx  <= shift[0];
            cnt <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx <= par;
`else
              tx <= 1'b1;
`endif
            end else begin
              shift <= {1'b0, shift[7:1]};
              cnt   <= cnt + 3'd1;
              tx    <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (tick) tx <= 1'b1;
`endif
        S_STOP:  tx <= 1'b1;
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed and random frames at varying baud
// divisors, compared cycle by cycle against a frame model built from the
// byte value (start 0, data LSB-first, optional even parity, stop 1).

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  int unsigned div    = 0;
  bit          tick_en = 1'b0;
  int unsigned tcnt   = 0;
  int          checks = 0;
  int          errors = 0;

  uart_tx dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Baud strobe: high one cycle in every div+1, driven at negedge
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && tcnt >= div) begin
        tick = 1'b1;
        tcnt = 0;
      end else begin
        tick = 1'b0;
        tcnt = tick_en ? tcnt + 1 : 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected line level for frame position i of byte b
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 1 && i <= 8) return ((int'(b) >> (i - 1)) % 2) == 1;
    if (FLEN == 11 && i == 9) return ($countones(b) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Send one byte. hold keeps valid high across the frame; inj pulses
  // valid with 0xFF at the start of that frame bit; abort resets at the
  // start of that frame bit and ends the frame there.
  task automatic send(input logic [7:0] b, input int unsigned d,
                      input bit hold, input int inj, input int abort);
    int n;
    int lat;
    div   = d;
    data  = b;
    valid = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("ready_before_accept", ready, 1'b1);
    step();
    if (!hold) valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("ready_after_accept", ready, 1'b0);
    chk("sync_tx_high", tx, 1'b1);
    lat = 0;
    while (tx !== 1'b0 && lat <= int'(d) + 1) begin
      step();
      lat++;
    end
    chk("start_latency", (lat >= 1 && lat <= int'(d) + 1), 1'b1);
    if (d == 0) chk("start_latency_exact", lat == 1, 1'b1);
    for (int i = 0; i < FLEN; i++) begin
      for (int k = 0; k <= int'(d); k++) begin
        chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, i, k), tx, exp_bit(b, i));
        chk("busy_in_frame", busy, 1'b1);
        if (i == abort && k == 0) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          chk("abort_tx_idle", tx, 1'b1);
          chk("abort_ready", ready, 1'b1);
          chk("abort_busy", busy, 1'b0);
          valid = 1'b0;
          return;
        end
        if (i == inj && k == 0) begin
          valid = 1'b1;
          data  = 8'hFF;
        end
        step();
        if (i == inj && k == 0 && !hold) valid = 1'b0;
      end
    end
    chk("ready_after_frame", ready, 1'b1);
    chk("busy_after_frame", busy, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h5A;
    tick_en = 1'b1;
    div   = 0;

    // Reset held two cycles with valid asserted
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    rst   = 1'b0;
    valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_tx_idle", tx, 1'b1);
      chk("post_rst_ready", ready, 1'b1);
    end

    // 0x55 at div=3
    send(8'h55, 3, 1'b0, -1, -1);

    // Back-to-back 0xA3 then 0x0F, valid held, tick every cycle
    send(8'hA3, 0, 1'b1, -1, -1);
    send(8'h0F, 0, 1'b0, -1, -1);

    // Valid pulsed with 0xFF during data bit 3 of a 0x00 frame
    send(8'h00, 2, 1'b0, 4, -1);

    // Reset during data bit 4, then 0x81
    send(8'hC6, 2, 1'b0, -1, 5);
    send(8'h81, 2, 1'b0, -1, -1);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1, 1'b0, -1, -1);
    send(8'h03, 1, 1'b0, -1, -1);
`endif

    // Random bytes at random divisors
    for (int r = 0; r < 10; r++) begin
      send(8'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, -1);
    end
    valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit stage sitting directly downstream of the programmable clock divider. The divider's one-cycle strobe sets the baud rate, and this block consumes it: it accepts a byte over a valid/ready handshake and shifts it out LSB-first on a single line as an 8-N-1 frame (optionally 8-E-1). Every bit holds for exactly one strobe period, so baud rate equals clk / (div + 1).

## Interface
Parameters
- none; width fixed at 8 data bits.

Ports
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  baud strobe; high for one clk cycle per bit period (divider output).
- data  in  8  byte to transmit; sampled only on accept.
- valid  in  1  producer has a byte on data.
- ready  out  1  block can accept; high only in IDLE.
- tx  out  1  serial line, registered, idle-high.
- busy  out  1  high from accept until the stop bit completes; equals !ready.

## Operation
- Accept: valid && ready on a posedge. Latch data into the shift register and go to SYNC.
- States and transitions. All transitions except accept happen only on a cycle where tick is high.
  - IDLE: tx=1, ready=1.
  - SYNC: wait for the first tick after accept. On tick, tx<=0 and go to START.
  - START: on tick, tx<=shift[0], bit counter<=0, go to DATA.
  - DATA: on tick, if counter==7 go to STOP (or PARITY when enabled) and drive tx=1 (or the parity bit). Otherwise shift right, counter+1, tx<=next bit.
  - PARITY: on tick, tx<=1, go to STOP.
  - STOP: on tick, go to IDLE. tx stays 1.
- Bit counter is 3 bits and must never wrap inside DATA; the exit condition is checked at 7.
- A tick in the same cycle as accept is ignored. SYNC samples tick from the following cycle.
- valid while busy is ignored. data changes while busy do not affect the frame in flight.
- tick held high continuously is legal and gives one bit per clk cycle.
- tick absent means the FSM holds its state and tx holds its value indefinitely.

## Timing
- Reset values: tx=1, ready=1, busy=0, state=IDLE, shift=0, counter=0.
- Reset mid-frame: frame abandoned. tx=1 and ready=1 on the cycle after the reset edge; no partial stop bit is generated.
- Start-bit latency: tx falls on the edge of the first tick strictly after the accept edge.
- Each bit lasts exactly one tick period, i.e. div+1 clk cycles.
- Frame length is 10 tick periods, or 11 with parity. ready rises on the edge of the tick that ends the stop bit.
- Back-to-back: a new accept is possible in the cycle ready rises. The next start bit then waits for the following tick, so there are no gaps beyond one stop bit.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is compiled in.
  - An even-parity bit (XOR of the 8 data bits) is sent between data bit 7 and the stop bit.
  - Frame is 11 bits.
- UART_TX_PARITY_EN undefined:
  - PARITY state and parity logic are absent.
  - DATA goes directly to STOP.
  - Frame is 10 bits.

## Test plan
- Reset check: assert rst for 2 cycles with valid=1. Required: tx=1, ready=1, busy=0 throughout, and no frame starts.
- Single byte 0x55, divider at div=3 (tick every 4 cycles). Required: tx sequence 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 cycles; ready returns after 40 cycles from the start-bit edge.
- Back-to-back 0xA3 then 0x0F, valid held high, tick every cycle. Required:
  - line pattern 0,1,1,0,0,0,1,0,1,1 followed by 0,1,1,1,1,0,0,0,0,1;
  - no idle cycle between frames beyond the SYNC wait.
- Handshake under load: pulse valid during DATA with data=0xFF. Required: ignored, and the in-flight 0x00 frame transmits unchanged.
- Reset mid-frame: assert rst during data bit 4. Required: tx=1 next cycle, ready=1, and a subsequent 0x81 frame is correct.
- With UART_TX_PARITY_EN: send 0x07. Required: parity bit 1, frame 0,1,1,1,0,0,0,0,0,1,1 (11 bits).
- With UART_TX_PARITY_EN: send 0x03. Required: parity bit 0.
